clk_lock_seq: RTL and testbench

Lock monitor and reset sequencer sitting directly downstream of the DLL wrapper. It consumes the DLL `locked` status and runs in the 40 MHz fabric clock domain (DLL 40 MHz, 0° output). It releases the core reset only after lock has been stable for a programmable time, then raises `ready`. It re-asserts reset on loss of lock, requests a DLL relock if lock never arrives, and keeps sticky lock-loss status.

---
 rtl/clk_lock_seq.sv | 196 +++++++++++++++++++
 tb/tb_clk_lock_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_lock_seq.sv
`timescale 1ns/1ps
// clk_lock_seq: DLL lock monitor and core reset sequencer (fabric clock domain).
// Synchronizes the asynchronous DLL lock status and counts consecutive locked
// cycles. When lock has been stable long enough, the core reset is released,
// and after a further delay ready is raised. Lock loss after release puts the
// core back into reset and sets a sticky status flag. If lock never arrives in
// time, a fixed-width relock request pulse is issued.
//
// Optional feature macro: CLK_LOCK_LOSS_CNT_EN adds the 8-bit saturating
// lock_loss_cnt register and port.
//
// Ports:
//   clk           fabric clock (DLL 0 deg output)
//   rst_n         synchronous active-low reset
//   locked        DLL lock status, asynchronous to clk
//   clr_stat      single-cycle clear of lost_lock / lock_loss_cnt
//   core_rst_n    active-low reset to downstream logic
//   ready         clocks stable and core out of reset
//   relock_req    DLL relock request pulse, RELOCK_W cycles wide
//   lost_lock     sticky lock-loss flag
//   lock_loss_cnt saturating lock-loss count (macro builds only)
//   state         current FSM state code (debug)
module clk_lock_seq #(
  parameter int unsigned STABLE_CYC  = 1024,
  parameter int unsigned READY_DLY   = 16,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned RELOCK_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       clr_stat,
  output logic       core_rst_n,
  output logic       ready,
  output logic       relock_req,
  output logic       lost_lock,
`ifdef CLK_LOCK_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic [2:0] state
);

  localparam int unsigned STAB_W = ($clog2(STABLE_CYC)  > 0) ? $clog2(STABLE_CYC)  : 1;
  localparam int unsigned DLY_W  = ($clog2(READY_DLY)   > 0) ? $clog2(READY_DLY)   : 1;
  localparam int unsigned TO_W   = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RL_W   = ($clog2(RELOCK_W)    > 0) ? $clog2(RELOCK_W)    : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYC - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(READY_DLY - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RL_W-1:0]   RL_LAST   = RL_W'(RELOCK_W - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    RELOCK    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              sync1_q, locked_s_q;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [RL_W-1:0]   rl_cnt_q, rl_cnt_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              ready_q, ready_d;
  logic              relock_req_q, relock_req_d;
  logic              lost_lock_q, lost_lock_d;
  logic              loss;

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      locked_s_q   <= 1'b0;
      state_q      <= WAIT_LOCK;
      stab_cnt_q   <= '0;
      dly_cnt_q    <= '0;
      to_cnt_q     <= '0;
      rl_cnt_q     <= '0;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      relock_req_q <= 1'b0;
      lost_lock_q  <= 1'b0;
    end else begin
      sync1_q      <= locked;
      locked_s_q   <= sync1_q;
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      dly_cnt_q    <= dly_cnt_d;
      to_cnt_q     <= to_cnt_d;
      rl_cnt_q     <= rl_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      ready_q      <= ready_d;
      relock_req_q <= relock_req_d;
      lost_lock_q  <= lost_lock_d;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    dly_cnt_d  = dly_cnt_q;
    to_cnt_d   = to_cnt_q;
    rl_cnt_d   = rl_cnt_q;
    loss       = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        stab_cnt_d = locked_s_q ? (stab_cnt_q + STAB_W'(1)) : '0;
        to_cnt_d   = to_cnt_q + TO_W'(1);
        // Release wins over timeout when both land on the same cycle
        if (locked_s_q && (stab_cnt_q == STAB_LAST)) begin
          state_d    = RELEASE;
          stab_cnt_d = '0;
          to_cnt_d   = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d    = RELOCK;
          stab_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (!locked_s_q) begin
          loss = 1'b1;
        end else if (dly_cnt_q == DLY_LAST) begin
          state_d   = RUN;
          dly_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      RUN: begin
        if (!locked_s_q) loss = 1'b1;
      end
      RELOCK: begin
        // locked_s is deliberately ignored until the pulse completes
        if (rl_cnt_q == RL_LAST) begin
          state_d  = WAIT_LOCK;
          rl_cnt_d = '0;
        end else begin
          rl_cnt_d = rl_cnt_q + RL_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (loss) begin
      state_d    = WAIT_LOCK;
      stab_cnt_d = '0;
      dly_cnt_d  = '0;
      to_cnt_d   = '0;
      rl_cnt_d   = '0;
    end

    // A loss on the same cycle as a clear leaves the flag set
    lost_lock_d = lost_lock_q;
    if (clr_stat) lost_lock_d = 1'b0;
    if (loss)     lost_lock_d = 1'b1;

    // Outputs follow the next state so they change on the transition edge
    core_rst_n_d = (state_d == RELEASE) || (state_d == RUN);
    ready_d      = (state_d == RUN);
    relock_req_d = (state_d == RELOCK);
  end

`ifdef CLK_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating lock-loss counter; a concurrent loss restarts it at 1
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (clr_stat) loss_cnt_d = '0;
    if (loss) begin
      if (clr_stat)                 loss_cnt_d = 8'd1;
      else if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

  assign core_rst_n = core_rst_n_q;
  assign ready      = ready_q;
  assign relock_req = relock_req_q;
  assign lost_lock  = lost_lock_q;
  assign state      = 3'(state_q);

endmodule

// File: tb/tb_clk_lock_seq.sv
`timescale 1ns/1ps
// Directed bench for clk_lock_seq with small parameters.
module tb_clk_lock_seq;

  logic       clk = 1'b0;
  logic       rst_n, locked, clr_stat;
  logic       core_rst_n, ready, relock_req, lost_lock;
  logic [2:0] state;
`ifdef CLK_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  clk_lock_seq #(
    .STABLE_CYC (8),
    .READY_DLY  (4),
    .TIMEOUT_CYC(64),
    .RELOCK_W   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked       (locked),
    .clr_stat     (clr_stat),
    .core_rst_n   (core_rst_n),
    .ready        (ready),
    .relock_req   (relock_req),
    .lost_lock    (lost_lock),
`ifdef CLK_LOCK_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .state        (state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns so outputs are sampled off-edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    locked   = 1'b0;
    clr_stat = 1'b0;
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_relock_req", 32'(relock_req), 32'd0);
    chk("rst_lost_lock", 32'(lost_lock), 32'd0);
`ifdef CLK_LOCK_LOSS_CNT_EN
    chk("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
`endif

    // Lock held: release 10 cycles after first sample, ready 4 later
    rst_n  = 1'b1;
    locked = 1'b1;
    step(9);
    chk("s1_core_rst_n_early", 32'(core_rst_n), 32'd0);
    chk("s1_state_wait", 32'(state), 32'd0);
    step(1);
    chk("s1_core_rst_n_rise", 32'(core_rst_n), 32'd1);
    chk("s1_state_release", 32'(state), 32'd1);
    chk("s1_ready_low", 32'(ready), 32'd0);
    step(3);
    chk("s1_ready_early", 32'(ready), 32'd0);
    step(1);
    chk("s1_ready_rise", 32'(ready), 32'd1);
    chk("s1_state_run", 32'(state), 32'd2);

    // Lock loss in RUN: reset reasserted 3 cycles after the drop is sampled
    locked = 1'b0;
    step(2);
    chk("s4_core_rst_n_hold", 32'(core_rst_n), 32'd1);
    chk("s4_state_hold", 32'(state), 32'd2);
    step(1);
    chk("s4_core_rst_n_fall", 32'(core_rst_n), 32'd0);
    chk("s4_ready_fall", 32'(ready), 32'd0);
    chk("s4_lost_lock", 32'(lost_lock), 32'd1);
    chk("s4_state_wait", 32'(state), 32'd0);
`ifdef CLK_LOCK_LOSS_CNT_EN
    chk("s4_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif
    clr_stat = 1'b1;
    step(1);
    clr_stat = 1'b0;
    chk("s4_clr_lost_lock", 32'(lost_lock), 32'd0);
`ifdef CLK_LOCK_LOSS_CNT_EN
    chk("s4_clr_loss_cnt", 32'(lock_loss_cnt), 32'd0);
`endif

    // One-cycle dropout during stabilization restarts the count
    rst_n = 1'b0;
    step(1);
    rst_n  = 1'b1;
    locked = 1'b1;
    step(5);
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(9);
    chk("s2_core_rst_n_early", 32'(core_rst_n), 32'd0);
    step(1);
    chk("s2_core_rst_n_rise", 32'(core_rst_n), 32'd1);
    step(4);
    chk("s2_state_run", 32'(state), 32'd2);

    // 300 losses: first from RUN, the rest from RELEASE
    for (int i = 0; i < 300; i++) begin
      if (i != 0) begin
        locked = 1'b1;
        step(10);
      end
      locked = 1'b0;
      step(3);
`ifdef CLK_LOCK_LOSS_CNT_EN
      if (i == 99) chk("sat_loss_cnt_100", 32'(lock_loss_cnt), 32'd100);
`endif
    end
    chk("sat_lost_lock", 32'(lost_lock), 32'd1);
    chk("sat_core_rst_n", 32'(core_rst_n), 32'd0);
`ifdef CLK_LOCK_LOSS_CNT_EN
    chk("sat_loss_cnt_255", 32'(lock_loss_cnt), 32'd255);
`endif

    // clr_stat coinciding with a loss: the loss wins
    locked = 1'b1;
    step(14);
    chk("clr_state_run", 32'(state), 32'd2);
    locked = 1'b0;
    step(2);
    clr_stat = 1'b1;
    step(1);
    clr_stat = 1'b0;
    chk("clr_loss_lost_lock", 32'(lost_lock), 32'd1);
    chk("clr_loss_state", 32'(state), 32'd0);
`ifdef CLK_LOCK_LOSS_CNT_EN
    chk("clr_loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif
    clr_stat = 1'b1;
    step(1);
    clr_stat = 1'b0;
    chk("clr_alone_lost_lock", 32'(lost_lock), 32'd0);
`ifdef CLK_LOCK_LOSS_CNT_EN
    chk("clr_alone_loss_cnt", 32'(lock_loss_cnt), 32'd0);
`endif

    // Lock never arrives: relock_req high for cycles 64..67, repeating every 68
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(63);
    chk("to_relock_early", 32'(relock_req), 32'd0);
    chk("to_state_wait", 32'(state), 32'd0);
    step(1);
    chk("to_relock_rise", 32'(relock_req), 32'd1);
    chk("to_state_relock", 32'(state), 32'd3);
    locked = 1'b1;
    step(3);
    chk("to_relock_last", 32'(relock_req), 32'd1);
    locked = 1'b0;
    step(1);
    chk("to_relock_fall", 32'(relock_req), 32'd0);
    chk("to_state_back", 32'(state), 32'd0);
    step(63);
    chk("to2_relock_early", 32'(relock_req), 32'd0);
    step(1);
    chk("to2_relock_rise", 32'(relock_req), 32'd1);
    chk("to_lost_lock", 32'(lost_lock), 32'd0);
    chk("to_core_rst_n", 32'(core_rst_n), 32'd0);

    // Reset during the relock pulse truncates it
    step(1);
    chk("rl_relock_mid", 32'(relock_req), 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("rl_rst_relock", 32'(relock_req), 32'd0);
    chk("rl_rst_state", 32'(state), 32'd0);
    chk("rl_rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rl_rst_ready", 32'(ready), 32'd0);
    chk("rl_rst_lost_lock", 32'(lost_lock), 32'd0);
    rst_n = 1'b1;
    step(60);
    chk("rl_after_rst_quiet", 32'(relock_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
